// File: rtl/moore_det_pkg.sv
// Shared types and helpers for the multi-channel Moore sequence detector.
package moore_det_pkg;

  typedef enum logic {
    MODE_NONOVL = 1'b0,
    MODE_OVL    = 1'b1
  } det_mode_e;

  // Stored pattern length is always at least one bit and never longer than the history.
  function automatic int clamp_len(input int raw_len, input int max_len);
    if (raw_len < 1) return 1;
    if (raw_len > max_len) return max_len;
    return raw_len;
  endfunction

  function automatic int cnt_sat(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/moore_det_chan.sv
// One detector channel: bit history, fill level, registered match and saturating hit counter.
module moore_det_chan
  import moore_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cfg_we,
  input  logic             clr_cnt,
  input  logic             x,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] len,
  input  det_mode_e        mode,
  output logic             match,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(cnt_sat(CNT_W));
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_n;
  logic [PAT_W-1:0] len_mask;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] fill_n;
  logic [CNT_W-1:0] cnt_base;
  logic             hit;

  // fill counts bits collected since the last clear, so a hit can never use stale history
  always_comb begin
    hist_n   = {hist[PAT_W-2:0], x};
    fill_n   = (fill == FILL_MAX) ? fill : fill + 1'b1;
    len_mask = ~({PAT_W{1'b1}} << len);
    hit      = (fill_n >= len) && (((hist_n ^ pat) & len_mask) == '0);
    cnt_base = clr_cnt ? '0 : cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
      cnt   <= '0;
    end else begin
      cnt <= cnt_base;
      if (cfg_we) begin
        hist  <= '0;
        fill  <= '0;
        match <= 1'b0;
      end else if (ena) begin
        hist  <= hist_n;
        match <= hit;
        fill  <= (hit && (mode == MODE_NONOVL)) ? '0 : fill_n;
        if (hit && (cnt_base != CNT_MAX)) begin
          cnt <= cnt_base + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/moore_seq_detector_n.sv
// Multi-channel Moore sequence detector: shared runtime pattern config, per-channel detectors, counter readout mux.
module moore_seq_detector_n
  import moore_det_pkg::*;
#(
  parameter  int N_CH  = 2,
  parameter  int PAT_W = 8,
  parameter  int CNT_W = 8,
  parameter  int LEN_W = $clog2(PAT_W + 1),
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [N_CH-1:0]  x,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             clr_cnt,
  input  logic [SEL_W-1:0] cnt_sel,
  output logic [N_CH-1:0]  match,
  output logic [CNT_W-1:0] cnt_out
);

  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  det_mode_e        mode_q;
  logic [CNT_W-1:0] cnt_arr [N_CH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_q  <= '0;
      len_q  <= LEN_W'(1);
      mode_q <= MODE_OVL;
    end else if (cfg_we) begin
      pat_q  <= cfg_pat;
      len_q  <= LEN_W'(clamp_len(int'(cfg_len), PAT_W));
      mode_q <= det_mode_e'(cfg_overlap);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    moore_det_chan #(
      .PAT_W(PAT_W),
      .CNT_W(CNT_W),
      .LEN_W(LEN_W)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .cfg_we (cfg_we),
      .clr_cnt(clr_cnt),
      .x      (x[i]),
      .pat    (pat_q),
      .len    (len_q),
      .mode   (mode_q),
      .match  (match[i]),
      .cnt    (cnt_arr[i])
    );
  end

  // Selecting a channel that does not exist reads back zero
  always_comb begin
    cnt_out = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (int'(cnt_sel) == i) cnt_out = cnt_arr[i];
    end
  end

endmodule

// File: tb/tb_moore_seq_detector_n.sv
// Self-checking bench: vector table, directed corner sequences and random traffic against a queue-based model.
module tb_moore_seq_detector_n;

  localparam int N_CH  = 2;
  localparam int PAT_W = 8;
  localparam int CNT_W = 4;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ena;
  logic [N_CH-1:0]  x;
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pat;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             clr_cnt;
  logic [0:0]       cnt_sel;
  logic [N_CH-1:0]  match;
  logic [CNT_W-1:0] cnt_out;

  int n_checks = 0;
  int n_fail   = 0;

  moore_seq_detector_n #(
    .N_CH (N_CH),
    .PAT_W(PAT_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .x          (x),
    .cfg_we     (cfg_we),
    .cfg_pat    (cfg_pat),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .clr_cnt    (clr_cnt),
    .cnt_sel    (cnt_sel),
    .match      (match),
    .cnt_out    (cnt_out)
  );

  always #5 clk = ~clk;

  // Reference model: every enabled sample vector kept in a queue; each channel
  // remembers how many samples it may still use since its last clear.
  logic [N_CH-1:0] samp_q [$];
  int              fresh  [N_CH];
  int              m_cnt  [N_CH];
  logic [N_CH-1:0] m_match;
  logic [PAT_W-1:0] m_pat;
  int              m_len;
  logic            m_ovl;

  function automatic void model_step(input logic r, input logic e, input logic [N_CH-1:0] xv,
                                     input logic we, input logic [PAT_W-1:0] p,
                                     input logic [LEN_W-1:0] l, input logic o, input logic c);
    if (!r) begin
      samp_q.delete();
      for (int ch = 0; ch < N_CH; ch++) begin
        fresh[ch] = 0;
        m_cnt[ch] = 0;
      end
      m_match = '0;
      m_pat   = '0;
      m_len   = 1;
      m_ovl   = 1'b1;
    end else begin
      if (c) for (int ch = 0; ch < N_CH; ch++) m_cnt[ch] = 0;
      if (we) begin
        m_pat = p;
        m_len = (int'(l) < 1) ? 1 : ((int'(l) > PAT_W) ? PAT_W : int'(l));
        m_ovl = o;
        samp_q.delete();
        for (int ch = 0; ch < N_CH; ch++) fresh[ch] = 0;
        m_match = '0;
      end else if (e) begin
        samp_q.push_back(xv);
        if (samp_q.size() > 32) void'(samp_q.pop_front());
        for (int ch = 0; ch < N_CH; ch++) begin
          bit ok;
          if (fresh[ch] < 64) fresh[ch]++;
          ok = (fresh[ch] >= m_len);
          if (ok) begin
            for (int k = 0; k < m_len; k++) begin
              logic [N_CH-1:0] s;
              s = samp_q[samp_q.size() - 1 - k];
              if (s[ch] != m_pat[k]) ok = 1'b0;
            end
          end
          m_match[ch] = ok;
          if (ok) begin
            if (!m_ovl) fresh[ch] = 0;
            if (m_cnt[ch] < 15) m_cnt[ch]++;
          end
        end
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic checkModel();
    checkOutput("model_match", 32'(match), 32'(m_match));
    checkOutput("model_cnt", 32'(cnt_out), 32'(m_cnt[int'(cnt_sel)]));
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [N_CH-1:0] xv,
                               input logic we, input logic [PAT_W-1:0] p,
                               input logic [LEN_W-1:0] l, input logic o, input logic c,
                               input logic s);
    rst_n = r; ena = e; x = xv; cfg_we = we; cfg_pat = p; cfg_len = l;
    cfg_overlap = o; clr_cnt = c; cnt_sel = s;
    @(posedge clk);
    model_step(r, e, xv, we, p, l, o, c);
    #1;
    checkModel();
  endtask

  task automatic sample(input logic [N_CH-1:0] xv);
    applyStimulus(1'b1, 1'b1, xv, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic s);
    applyStimulus(1'b1, 1'b0, N_CH'($urandom), 1'b0, '0, '0, 1'b0, 1'b0, s);
  endtask

  task automatic load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic o);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, p, l, o, 1'b1, 1'b0);
  endtask

  typedef struct {
    logic             r, e;
    logic [N_CH-1:0]  xv;
    logic             we;
    logic [PAT_W-1:0] p;
    logic [LEN_W-1:0] l;
    logic             o, c, s;
    logic [N_CH-1:0]  em;
    logic [CNT_W-1:0] ec;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [PAT_W-1:0] pv;
    bit s1011 [7];
    bit e_ovl [7];
    bit e_non [7];

    // pattern 01, len 2, overlapping, ch0 stream 0,1,0,1,0,1 then hold/readout/clear
    vecs[0]  = '{1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0};
    vecs[1]  = '{1'b1, 1'b0, 2'b00, 1'b1, 8'h01, 4'd2, 1'b1, 1'b0, 1'b0, 2'b00, 4'd0};
    vecs[2]  = '{1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0};
    vecs[3]  = '{1'b1, 1'b1, 2'b01, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 2'b01, 4'd1};
    vecs[4]  = '{1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd1};
    vecs[5]  = '{1'b1, 1'b1, 2'b01, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 2'b01, 4'd2};
    vecs[6]  = '{1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd2};
    vecs[7]  = '{1'b1, 1'b1, 2'b01, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 2'b01, 4'd3};
    vecs[8]  = '{1'b1, 1'b0, 2'b10, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 2'b01, 4'd3};
    vecs[9]  = '{1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 2'b01, 4'd0};
    vecs[10] = '{1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 2'b01, 4'd0};

    s1011 = '{1, 0, 1, 1, 0, 1, 1};
    e_ovl = '{0, 0, 0, 1, 0, 0, 1};
    e_non = '{0, 0, 0, 1, 0, 0, 0};

    rst_n = 1'b0; ena = 1'b0; x = '0; cfg_we = 1'b0; cfg_pat = '0; cfg_len = '0;
    cfg_overlap = 1'b0; clr_cnt = 1'b0; cnt_sel = 1'b0;

    $display("[TB] vector table");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].r, vecs[i].e, vecs[i].xv, vecs[i].we, vecs[i].p, vecs[i].l,
                    vecs[i].o, vecs[i].c, vecs[i].s);
      checkOutput($sformatf("vec%0d_match", i), 32'(match), 32'(vecs[i].em));
      checkOutput($sformatf("vec%0d_cnt", i), 32'(cnt_out), 32'(vecs[i].ec));
    end

    $display("[TB] 1011 overlap / non-overlap");
    load(8'b1011, 4'd4, 1'b1);
    for (int i = 0; i < 7; i++) begin
      sample({1'b0, s1011[i]});
      checkOutput($sformatf("ovl_s%0d", i + 1), 32'(match[0]), 32'(e_ovl[i]));
    end
    checkOutput("ovl_cnt", 32'(cnt_out), 32'd2);
    load(8'b1011, 4'd4, 1'b0);
    for (int i = 0; i < 7; i++) begin
      sample({1'b0, s1011[i]});
      checkOutput($sformatf("nonovl_s%0d", i + 1), 32'(match[0]), 32'(e_non[i]));
    end
    checkOutput("nonovl_cnt", 32'(cnt_out), 32'd1);

    $display("[TB] counter saturation");
    load(8'h01, 4'd1, 1'b1);
    for (int i = 0; i < 20; i++) sample(2'b01);
    checkOutput("sat_match", 32'(match[0]), 32'd1);
    checkOutput("sat_cnt", 32'(cnt_out), 32'd15);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("clr_cnt", 32'(cnt_out), 32'd0);
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("clr_and_hit_cnt", 32'(cnt_out), 32'd1);

    $display("[TB] mid-stream reset and reconfig");
    load(8'b1011, 4'd4, 1'b1);
    sample(2'b01); sample(2'b00); sample(2'b01);
    applyStimulus(1'b0, 1'b1, 2'b11, 1'b1, 8'hFF, 4'd1, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_match", 32'(match), 32'd0);
    checkOutput("rst_cnt", 32'(cnt_out), 32'd0);
    sample(2'b01);
    checkOutput("rst_no_match", 32'(match[0]), 32'd0);
    load(8'b1011, 4'd4, 1'b1);
    sample(2'b01); sample(2'b00); sample(2'b01);
    load(8'b1011, 4'd4, 1'b1);
    sample(2'b01);
    checkOutput("cfg_no_match", 32'(match[0]), 32'd0);
    sample(2'b00); sample(2'b01); sample(2'b01);
    checkOutput("cfg_fresh_match", 32'(match[0]), 32'd1);

    $display("[TB] channel independence with enable gaps");
    load(8'b1011, 4'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      sample({1'b0, s1011[i]});
      checkOutput($sformatf("gap_s%0d", i + 1), 32'(match), (i == 3) ? 32'd1 : 32'd0);
    end
    idle(1'b0);
    checkOutput("gap_hold", 32'(match), 32'd1);
    idle(1'b1);
    checkOutput("sel1_cnt", 32'(cnt_out), 32'd0);
    idle(1'b0);
    checkOutput("sel0_cnt", 32'(cnt_out), 32'd1);
    applyStimulus(1'b1, 1'b1, 2'b11, 1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
    checkOutput("cfg_beats_ena", 32'(match), 32'd0);

    $display("[TB] length clamping");
    load(8'hA5, 4'd0, 1'b1);
    sample(2'b01);
    checkOutput("len0_hit", 32'(match[0]), 32'd1);
    sample(2'b00);
    checkOutput("len0_miss", 32'(match[0]), 32'd0);
    load(8'hA5, 4'd11, 1'b1);
    pv = 8'hA5;
    for (int k = PAT_W - 1; k >= 0; k--) begin
      sample({1'b0, pv[k]});
      checkOutput($sformatf("lenmax_b%0d", k), 32'(match[0]), (k == 0) ? 32'd1 : 32'd0);
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 800; i++) begin
      logic [LEN_W-1:0] l;
      l = ($urandom_range(0, 7) == 0) ? LEN_W'($urandom_range(0, 15)) : LEN_W'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, N_CH'($urandom),
                    $urandom_range(0, 29) == 0, PAT_W'($urandom), l, 1'($urandom),
                    $urandom_range(0, 39) == 0, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
